// File: rtl/btc_miner_regs_multi_pkg.sv
// ---------------------------------------------------------------------------
// btc_miner_pkg : address map, result entry layout and helpers -- rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package btc_miner_pkg;

  localparam logic [7:0] ADDR_CONFIG       = 8'h00;
  localparam logic [7:0] ADDR_VERSION      = 8'h04;
  localparam logic [7:0] ADDR_PREV_HASH0   = 8'h08;
  localparam logic [7:0] ADDR_PREV_HASH7   = 8'h24;
  localparam logic [7:0] ADDR_MERKLE0      = 8'h28;
  localparam logic [7:0] ADDR_MERKLE7      = 8'h44;
  localparam logic [7:0] ADDR_TIME         = 8'h48;
  localparam logic [7:0] ADDR_BITS         = 8'h4C;
  localparam logic [7:0] ADDR_NONCE_BASE   = 8'h50;
  localparam logic [7:0] ADDR_STATUS       = 8'h54;
  localparam logic [7:0] ADDR_RESULT_NONCE = 8'h58;
  localparam logic [7:0] ADDR_RESULT_INFO  = 8'h5C;
  localparam logic [7:0] ADDR_PARAMS       = 8'h60;

  localparam int NONCE_W         = 32;
  localparam int CORE_ID_FIELD_W = 3;
  localparam int ENTRY_W         = CORE_ID_FIELD_W + 1 + NONCE_W;

  function automatic int CORE_ID_W(input int n);
    int w;
    w = 0;
    for (int k = 0; k < 31; k++) begin
      if ((1 << k) < n) w = k + 1;
    end
    return w;
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] data,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = data[8*b +: 8];
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/btc_miner_regs_multi_if.sv
// ---------------------------------------------------------------------------
// btc_miner_regs_multi_if : classic Wishbone slave bus bundle -- rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface btc_miner_regs_multi_if;
  logic [7:0]  wbAddr;
  logic [3:0]  wbSel;
  logic        wbWe;
  logic [31:0] wbWData;
  logic        wbCycle;
  logic        wbStrobe;
  logic [2:0]  wbCti;
  logic [1:0]  wbBte;
  logic [31:0] wbRData;
  logic        wbAck;
  logic        wbErr;
  logic        wbRty;

  modport master (
    output wbAddr, wbSel, wbWe, wbWData, wbCycle, wbStrobe, wbCti, wbBte,
    input  wbRData, wbAck, wbErr, wbRty
  );

  modport slave (
    input  wbAddr, wbSel, wbWe, wbWData, wbCycle, wbStrobe, wbCti, wbBte,
    output wbRData, wbAck, wbErr, wbRty
  );
endinterface

`default_nettype wire

// File: rtl/btc_miner_regs_multi_fifo.sv
// ---------------------------------------------------------------------------
// btc_result_fifo : synchronous result FIFO, head visible combinationally -- rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module btc_result_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign head  = r_mem[r_rd_ptr];

  // A pop frees the slot the same cycle, so a full FIFO still accepts a push alongside it.
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/btc_miner_regs_multi.sv
// ---------------------------------------------------------------------------
// btc_miner_regs_multi : Wishbone header/result registers for N miner cores;
// optional irq output with BTC_MINER_REGS_IRQ_EN -- rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module btc_miner_regs_multi
  import btc_miner_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      wbRstN,
  btc_miner_regs_multi_if.slave     wb,
  output logic [31:0]               version,
  output logic [255:0]              prev_hash,
  output logic [255:0]              merkle_root,
  output logic [31:0]               btime,
  output logic [31:0]               bits,
  output logic [NUM_CORES*32-1:0]   nonce_start,
  output logic                      start,
  output logic                      config_enable,
  output logic                      config_oneshot,
`ifdef BTC_MINER_REGS_IRQ_EN
  output logic                      irq,
`endif
  input  logic [NUM_CORES-1:0]      done_a,
  input  logic [NUM_CORES-1:0]      nonce_found_a,
  input  logic [NUM_CORES*32-1:0]   nonce_a
);

  localparam int LOG2_CORES = CORE_ID_W(NUM_CORES);
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

  // Bus-side registers
  logic              r_ack;
  logic [31:0]       r_rdata;
  logic [31:0]       r_version;
  logic [7:0][31:0]  r_prev_hash;
  logic [7:0][31:0]  r_merkle;
  logic [31:0]       r_time;
  logic [31:0]       r_bits;
  logic [31:0]       r_nonce_base;
  logic              r_start;
  logic              r_enable;
  logic              r_oneshot;
  logic              w_irq_en;

  // Result path
  logic [NUM_CORES-1:0]             r_sync1, r_sync2, r_sync3;
  logic [2:0]                       r_arm;
  logic [NUM_CORES-1:0]             w_event;
  logic [NUM_CORES-1:0]             r_pending;
  logic [NUM_CORES-1:0]             r_done;
  logic [NUM_CORES-1:0]             r_slot_found;
  logic [NUM_CORES-1:0][31:0]       r_slot_nonce;
  logic                             r_ovf;

  logic                             w_any;
  logic [CORE_ID_FIELD_W-1:0]       w_sel;
  logic [NUM_CORES-1:0]             w_sel_oh;
  logic                             w_push_found;
  logic [31:0]                      w_push_nonce;
  logic                             w_fifo_push;
  logic                             w_drop;
  logic [ENTRY_W-1:0]               w_head;
  logic                             w_full, w_empty;
  logic [CNT_W-1:0]                 w_count;

  logic        w_access, w_wr, w_rd, w_pop;
  logic        w_start_wr, w_ovf_clr;
  logic        w_in_ph, w_in_mk;
  logic [2:0]  w_ph_idx, w_mk_idx;
  logic [31:0] w_rdata;
  logic [31:0] w_config_rd;
  logic        w_unused_bits;

  assign w_unused_bits = ^{wb.wbCti, wb.wbBte};

  assign w_access   = wb.wbCycle & wb.wbStrobe & ~r_ack;
  assign w_wr       = w_access & wb.wbWe;
  assign w_rd       = w_access & ~wb.wbWe;
  assign w_pop      = w_rd & (wb.wbAddr == ADDR_RESULT_NONCE) & ~w_empty;
  assign w_start_wr = w_wr & (wb.wbAddr == ADDR_STATUS);
  assign w_ovf_clr  = w_start_wr & wb.wbSel[3] & wb.wbWData[31];

  assign w_in_ph  = (wb.wbAddr[1:0] == 2'b00) && (wb.wbAddr >= ADDR_PREV_HASH0) &&
                    (wb.wbAddr <= ADDR_PREV_HASH7);
  assign w_in_mk  = (wb.wbAddr[1:0] == 2'b00) && (wb.wbAddr >= ADDR_MERKLE0) &&
                    (wb.wbAddr <= ADDR_MERKLE7);
  assign w_ph_idx = 3'((wb.wbAddr - ADDR_PREV_HASH0) >> 2);
  assign w_mk_idx = 3'((wb.wbAddr - ADDR_MERKLE0) >> 2);

`ifdef BTC_MINER_REGS_IRQ_EN
  logic r_irq_en;
  logic r_irq;
  assign w_irq_en = r_irq_en;
  assign irq      = r_irq;

  always_ff @(posedge clk) begin
    if (!wbRstN) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr && wb.wbAddr == ADDR_CONFIG && wb.wbSel[0]) r_irq_en <= wb.wbWData[3];
      r_irq <= r_irq_en & ((w_count != '0) | r_ovf);
    end
  end
`else
  assign w_irq_en = 1'b0;
`endif

  assign w_config_rd = {28'b0, w_irq_en, r_oneshot, 1'b0, r_enable};

  always_comb begin
    w_rdata = '0;
    if (w_in_ph) begin
      w_rdata = r_prev_hash[w_ph_idx];
    end else if (w_in_mk) begin
      w_rdata = r_merkle[w_mk_idx];
    end else begin
      case (wb.wbAddr)
        ADDR_CONFIG:       w_rdata = w_config_rd;
        ADDR_VERSION:      w_rdata = r_version;
        ADDR_TIME:         w_rdata = r_time;
        ADDR_BITS:         w_rdata = r_bits;
        ADDR_NONCE_BASE:   w_rdata = r_nonce_base;
        ADDR_STATUS:       w_rdata = {r_ovf, 10'b0, 5'(w_count), 8'b0, 8'(r_done)};
        ADDR_RESULT_NONCE: w_rdata = w_empty ? 32'h0 : w_head[31:0];
        ADDR_RESULT_INFO:  w_rdata = w_empty ? 32'h0 :
                                     {23'b0, w_head[32], 5'b0, w_head[ENTRY_W-1 -: CORE_ID_FIELD_W]};
        ADDR_PARAMS:       w_rdata = {16'b0, 8'(FIFO_DEPTH), 8'(NUM_CORES)};
        default:           w_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!wbRstN) begin
      r_ack        <= 1'b0;
      r_rdata      <= '0;
      r_version    <= '0;
      r_prev_hash  <= '0;
      r_merkle     <= '0;
      r_time       <= '0;
      r_bits       <= '0;
      r_nonce_base <= '0;
      r_start      <= 1'b0;
      r_enable     <= 1'b0;
      r_oneshot    <= 1'b0;
    end else begin
      r_ack <= w_access;
      if (w_rd) r_rdata <= w_rdata;
      if (w_wr) begin
        if (w_in_ph) begin
          r_prev_hash[w_ph_idx] <= byte_merge(r_prev_hash[w_ph_idx], wb.wbWData, wb.wbSel);
        end else if (w_in_mk) begin
          r_merkle[w_mk_idx] <= byte_merge(r_merkle[w_mk_idx], wb.wbWData, wb.wbSel);
        end else begin
          case (wb.wbAddr)
            ADDR_CONFIG: begin
              if (wb.wbSel[0]) begin
                r_enable  <= wb.wbWData[0];
                r_oneshot <= wb.wbWData[2];
              end
            end
            ADDR_VERSION:    r_version    <= byte_merge(r_version, wb.wbWData, wb.wbSel);
            ADDR_TIME:       r_time       <= byte_merge(r_time, wb.wbWData, wb.wbSel);
            ADDR_BITS:       r_bits       <= byte_merge(r_bits, wb.wbWData, wb.wbSel);
            ADDR_NONCE_BASE: r_nonce_base <= byte_merge(r_nonce_base, wb.wbWData, wb.wbSel);
            ADDR_STATUS:     r_start      <= ~r_start;
            default:         ;
          endcase
        end
      end
    end
  end

  // Start nonces are registered so every output reads 0 while in reset.
  for (genvar g = 0; g < NUM_CORES; g++) begin : g_nonce
    localparam logic [63:0] OFFSET = 64'(g) << (32 - LOG2_CORES);
    logic [31:0] r_ns;
    always_ff @(posedge clk) begin
      if (!wbRstN) r_ns <= '0;
      else         r_ns <= r_nonce_base + OFFSET[31:0];
    end
    assign nonce_start[32*g +: 32] = r_ns;
  end

  // r_arm masks the chain fill after reset so a level held on done_a is not seen as a toggle.
  always_ff @(posedge clk) begin
    if (!wbRstN) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_sync3 <= '0;
      r_arm   <= '0;
    end else begin
      r_sync1 <= done_a;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_arm   <= {r_arm[1:0], 1'b1};
    end
  end

  assign w_event = (r_sync2 ^ r_sync3) & {NUM_CORES{r_arm[2]}};

  always_comb begin
    w_any        = 1'b0;
    w_sel        = '0;
    w_sel_oh     = '0;
    w_push_found = 1'b0;
    w_push_nonce = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_any        = 1'b1;
        w_sel        = CORE_ID_FIELD_W'(i);
        w_sel_oh     = '0;
        w_sel_oh[i]  = 1'b1;
        w_push_found = r_slot_found[i];
        w_push_nonce = r_slot_nonce[i];
      end
    end
  end

  assign w_fifo_push = w_any & (~w_full | w_pop);
  assign w_drop      = w_any & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (!wbRstN) begin
      r_pending    <= '0;
      r_done       <= '0;
      r_slot_found <= '0;
      r_slot_nonce <= '0;
      r_ovf        <= 1'b0;
    end else begin
      if (w_start_wr) r_done <= '0;
      if (w_ovf_clr)  r_ovf  <= 1'b0;
      if (w_drop)     r_ovf  <= 1'b1;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (w_event[i]) begin
          r_slot_nonce[i] <= nonce_a[32*i +: 32];
          r_slot_found[i] <= nonce_found_a[i];
          r_pending[i]    <= 1'b1;
          r_done[i]       <= 1'b1;
        end else if (w_sel_oh[i]) begin
          r_pending[i] <= 1'b0;
        end
      end
    end
  end

  btc_result_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (wbRstN),
    .push      (w_fifo_push),
    .push_data ({w_sel, w_push_found, w_push_nonce}),
    .pop       (w_pop),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  assign wb.wbAck   = r_ack;
  assign wb.wbRData = r_rdata;
  assign wb.wbErr   = 1'b0;
  assign wb.wbRty   = 1'b0;

  assign version        = r_version;
  assign prev_hash      = r_prev_hash;
  assign merkle_root    = r_merkle;
  assign btime          = r_time;
  assign bits           = r_bits;
  assign start          = r_start;
  assign config_enable  = r_enable;
  assign config_oneshot = r_oneshot;

endmodule

`default_nettype wire

// File: tb/tb_btc_miner_regs_multi.sv
// ---------------------------------------------------------------------------
// tb_btc_miner_regs_multi : self-checking bench for btc_miner_regs_multi -- rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_btc_miner_regs_multi;

  localparam int NUM_CORES  = 4;
  localparam int FIFO_DEPTH = 4;

  logic          clk;
  logic          wbRstN;
  logic [31:0]   version, btime, bits;
  logic [255:0]  prev_hash, merkle_root;
  logic [127:0]  nonce_start;
  logic          start, config_enable, config_oneshot;
  logic [3:0]    done_a, nonce_found_a;
  logic [127:0]  nonce_a;
`ifdef BTC_MINER_REGS_IRQ_EN
  logic          irq;
`endif

  btc_miner_regs_multi_if bus ();

  btc_miner_regs_multi #(
    .NUM_CORES  (NUM_CORES),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk            (clk),
    .wbRstN         (wbRstN),
    .wb             (bus),
    .version        (version),
    .prev_hash      (prev_hash),
    .merkle_root    (merkle_root),
    .btime          (btime),
    .bits           (bits),
    .nonce_start    (nonce_start),
    .start          (start),
    .config_enable  (config_enable),
    .config_oneshot (config_oneshot),
`ifdef BTC_MINER_REGS_IRQ_EN
    .irq            (irq),
`endif
    .done_a         (done_a),
    .nonce_found_a  (nonce_found_a),
    .nonce_a        (nonce_a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  core;
    logic        found;
    logic [31:0] nonce;
  } entry_t;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  int       n_checks = 0;
  int       n_errors = 0;
  entry_t   sb[$];
  logic     exp_ovf;
  logic [3:0] exp_done;
  logic     exp_start;
  vec_t     vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wb_xfer(input logic [7:0] addr, input logic we, input logic [31:0] wdata,
                         input logic [3:0] sel, output logic [31:0] rdata);
    int n;
    @(negedge clk);
    bus.wbAddr   = addr;
    bus.wbWe     = we;
    bus.wbWData  = wdata;
    bus.wbSel    = sel;
    bus.wbCycle  = 1'b1;
    bus.wbStrobe = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.wbAck && n < 16);
    check("ack_latency", 64'(n), 64'd1);
    rdata = bus.wbRData;
    // strobe stays up one more cycle: the ack must still drop
    @(negedge clk);
    check("ack_single_cycle", {63'b0, bus.wbAck}, 64'd0);
    bus.wbCycle  = 1'b0;
    bus.wbStrobe = 1'b0;
    bus.wbWe     = 1'b0;
  endtask

  task automatic wb_write(input logic [7:0] addr, input logic [31:0] wdata, input logic [3:0] sel);
    logic [31:0] dummy;
    wb_xfer(addr, 1'b1, wdata, sel, dummy);
  endtask

  task automatic wb_read(input logic [7:0] addr, output logic [31:0] rdata);
    wb_xfer(addr, 1'b0, 32'h0, 4'hF, rdata);
  endtask

  task automatic read_status(input string name);
    logic [31:0] rd, exp;
    exp = {exp_ovf, 10'b0, 5'(sb.size()), 8'b0, 4'b0, exp_done};
    wb_read(8'h54, rd);
    check(name, 64'(rd), 64'(exp));
  endtask

  task automatic read_info();
    logic [31:0] rd, exp;
    exp = (sb.size() != 0) ? {23'b0, sb[0].found, 5'b0, sb[0].core} : 32'h0;
    wb_read(8'h5C, rd);
    check("result_info", 64'(rd), 64'(exp));
  endtask

  task automatic read_nonce();
    logic [31:0] rd, exp;
    exp = (sb.size() != 0) ? sb[0].nonce : 32'h0;
    wb_read(8'h58, rd);
    check("result_nonce", 64'(rd), 64'(exp));
    if (sb.size() != 0) void'(sb.pop_front());
  endtask

  task automatic write_status(input logic [31:0] data);
    wb_write(8'h54, data, 4'hF);
    exp_done  = '0;
    exp_start = ~exp_start;
    if (data[31]) exp_ovf = 1'b0;
    check("start_toggle", {63'b0, start}, {63'b0, exp_start});
  endtask

  // Toggle done_a for the masked cores; the model queues results lowest core first.
  task automatic fire(input logic [3:0] mask, input logic [3:0] found, input logic [127:0] nonces);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        nonce_a[32*i +: 32] = nonces[32*i +: 32];
        nonce_found_a[i]    = found[i];
        if (sb.size() < FIFO_DEPTH) sb.push_back('{3'(i), found[i], nonces[32*i +: 32]});
        else exp_ovf = 1'b1;
        exp_done[i] = 1'b1;
      end
    end
    done_a = done_a ^ mask;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] ns_exp[4];

    vecs[0]  = '{8'h04, 32'hAABBCCDD, 4'b0101, 32'h00BB00DD};
    vecs[1]  = '{8'h08, 32'h12345678, 4'b1111, 32'h12345678};
    vecs[2]  = '{8'h24, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF};
    vecs[3]  = '{8'h28, 32'hCAFEF00D, 4'b1100, 32'hCAFE0000};
    vecs[4]  = '{8'h44, 32'h0BADC0DE, 4'b1111, 32'h0BADC0DE};
    vecs[5]  = '{8'h48, 32'h5F5E1000, 4'b1111, 32'h5F5E1000};
    vecs[6]  = '{8'h4C, 32'h1D00FFFF, 4'b1111, 32'h1D00FFFF};
    vecs[7]  = '{8'h50, 32'hF0000000, 4'b1111, 32'hF0000000};
`ifdef BTC_MINER_REGS_IRQ_EN
    vecs[8]  = '{8'h00, 32'hFFFFFFFF, 4'b0001, 32'h0000000D};
`else
    vecs[8]  = '{8'h00, 32'hFFFFFFFF, 4'b0001, 32'h00000005};
`endif
    vecs[9]  = '{8'h60, 32'hFFFFFFFF, 4'b1111, 32'h00000404};
    vecs[10] = '{8'h70, 32'hFFFFFFFF, 4'b1111, 32'h00000000};
    ns_exp   = '{32'hF0000000, 32'h30000000, 32'h70000000, 32'hB0000000};

    exp_ovf = 1'b0; exp_done = '0; exp_start = 1'b0;
    bus.wbAddr = '0; bus.wbSel = '0; bus.wbWe = 1'b0; bus.wbWData = '0;
    bus.wbCycle = 1'b0; bus.wbStrobe = 1'b0; bus.wbCti = 3'b000; bus.wbBte = 2'b00;
    done_a = '0; nonce_found_a = '0; nonce_a = '0;
    wbRstN = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_version", 64'(version), 64'd0);
    check("rst_nonce_start_any", {63'b0, |nonce_start}, 64'd0);
    check("rst_ack", {63'b0, bus.wbAck}, 64'd0);
    check("rst_rdata", 64'(bus.wbRData), 64'd0);
    check("rst_err_rty", {62'b0, bus.wbErr, bus.wbRty}, 64'd0);
    wbRstN = 1'b1;
    read_status("status_after_reset");

    // register write/readback table
    for (int v = 0; v < 11; v++) begin
      wb_write(vecs[v].addr, vecs[v].wdata, vecs[v].sel);
      wb_read(vecs[v].addr, rd);
      check($sformatf("reg_rw_%02h", vecs[v].addr), 64'(rd), 64'(vecs[v].exp));
    end
    check("version_port", 64'(version), 64'h00BB00DD);
    check("prev_hash7_port", 64'(prev_hash[255:224]), 64'hDEADBEEF);
    check("merkle0_port", 64'(merkle_root[31:0]), 64'hCAFE0000);
    check("cfg_enable_port", {62'b0, config_enable, config_oneshot}, 64'd3);
    for (int i = 0; i < 4; i++) check($sformatf("nonce_start_%0d", i), 64'(nonce_start[32*i +: 32]), 64'(ns_exp[i]));

    // simultaneous completions on cores 0 and 2
    fire(4'b0101, 4'b0001, {32'h0, 32'h22, 32'h0, 32'h11});
    check("status_two_events", 64'(sb.size()), 64'd2);
    read_status("status_cnt2_done5");
    read_info();
    read_nonce();
    read_info();
    read_nonce();
    read_status("status_drained");
    write_status(32'h0);
    read_status("status_done_cleared");

    // overflow with no reads: five completions into a four-entry FIFO
    fire(4'b0001, 4'b0001, {96'h0, 32'h1000});
    fire(4'b0010, 4'b0000, {64'h0, 32'h1001, 32'h0});
    fire(4'b0100, 4'b0100, {32'h0, 32'h1002, 64'h0});
    fire(4'b1000, 4'b0000, {32'h1003, 96'h0});
    fire(4'b0001, 4'b0000, {96'h0, 32'h1004});
    check("overflow_model", {63'b0, exp_ovf}, 64'd1);
    read_status("status_full_overflow");
    for (int k = 0; k < 5; k++) begin
      read_info();
      read_nonce();
    end
    read_status("status_empty_overflow");
    write_status(32'h8000_0000);
    read_status("status_overflow_cleared");

`ifdef BTC_MINER_REGS_IRQ_EN
    wb_write(8'h00, 32'h0000_0008, 4'b0001);
    repeat (2) @(negedge clk);
    check("irq_idle", {63'b0, irq}, 64'd0);
    fire(4'b1000, 4'b1000, {32'hABCD0001, 96'h0});
    check("irq_pending", {63'b0, irq}, 64'd1);
    read_nonce();
    check("irq_cleared", {63'b0, irq}, 64'd0);
`endif

    // reset with three queued entries, done_a going high during reset
    fire(4'b1110, 4'b0000, {32'h3333, 32'h2222, 32'h1111, 32'h0});
    read_status("status_three_queued");
    @(negedge clk);
    wbRstN = 1'b0;
    done_a = 4'hF;
    repeat (2) @(negedge clk);
    check("rst2_hdr_any", {63'b0, |{version, prev_hash, merkle_root, btime, bits}}, 64'd0);
    check("rst2_ctrl", {61'b0, start, config_enable, config_oneshot}, 64'd0);
    check("rst2_nonce_start_any", {63'b0, |nonce_start}, 64'd0);
    check("rst2_bus", {31'b0, bus.wbAck, bus.wbRData}, 64'd0);
    wbRstN = 1'b1;
    sb.delete();
    exp_ovf = 1'b0; exp_done = '0; exp_start = 1'b0;
    repeat (10) @(negedge clk);
    read_status("status_after_mid_reset");
    read_nonce();

    // synchroniser still live after reset
    fire(4'b0010, 4'b0010, {64'h0, 32'h5A5A5A5A, 32'h0});
    read_status("status_post_reset_event");
    read_info();
    read_nonce();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
